// File: rtl/tt_heartbeat_multi.sv
// Multi-channel heartbeat generator. Each channel has its own prescaler and drives one pad
// in OFF / TOGGLE / PWM / PATTERN mode. Channel 0 also marks period boundaries for scope triggering.

module tt_heartbeat_ch #(
    parameter int DIV_WIDTH = 16,
    parameter int PAT_WIDTH = 8,
    parameter bit SYNC_EN   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 wr,
    input  logic [1:0]           cfg_mode,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [PAT_WIDTH-1:0] cfg_data,
    output logic                 pad_a,
    output logic                 pad_oe,
    output logic                 period_end
);
    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_TOGGLE  = 2'b01,
        MODE_PWM     = 2'b10,
        MODE_PATTERN = 2'b11
    } mode_e;

    localparam int IDX_W = $clog2(PAT_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_WIDTH - 1);

    mode_e                mode_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] presc_q;
    logic [PAT_WIDTH-1:0] data_q;      // PWM duty, or the rotating pattern
    logic [PAT_WIDTH-1:0] phase_q;
    logic [PAT_WIDTH-1:0] phase_nxt;
    logic [PAT_WIDTH-1:0] pat_rot;
    logic [IDX_W-1:0]     idx_q;
    logic                 tick;

    assign tick      = en && (presc_q == div_q);
    assign phase_nxt = phase_q + PAT_WIDTH'(1);
    assign pat_rot   = {data_q[PAT_WIDTH-2:0], data_q[PAT_WIDTH-1]};

    // A write on the tick cycle wins, so it also suppresses the period marker.
    always_comb begin
        period_end = 1'b0;
        if (SYNC_EN && tick && !wr) begin
            case (mode_q)
                MODE_TOGGLE:  period_end = pad_a;
                MODE_PWM:     period_end = (phase_nxt == '0);
                MODE_PATTERN: period_end = (idx_q == IDX_LAST);
                default:      period_end = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_OFF;
            div_q   <= '0;
            data_q  <= '0;
            presc_q <= '0;
            phase_q <= '0;
            idx_q   <= '0;
            pad_a   <= 1'b0;
            pad_oe  <= 1'b0;
        end else if (wr) begin
            mode_q  <= mode_e'(cfg_mode);
            div_q   <= cfg_div;
            data_q  <= cfg_data;
            presc_q <= '0;
            phase_q <= '0;
            idx_q   <= '0;
            pad_oe  <= (cfg_mode != MODE_OFF);
            case (mode_e'(cfg_mode))
                MODE_PWM:     pad_a <= (cfg_data != '0);
                MODE_PATTERN: pad_a <= cfg_data[PAT_WIDTH-1];
                default:      pad_a <= 1'b0;
            endcase
        end else if (en) begin
            presc_q <= tick ? '0 : presc_q + DIV_WIDTH'(1);
            if (tick) begin
                case (mode_q)
                    MODE_TOGGLE: pad_a <= !pad_a;
                    MODE_PWM: begin
                        phase_q <= phase_nxt;
                        pad_a   <= (phase_nxt < data_q);
                    end
                    MODE_PATTERN: begin
                        data_q <= pat_rot;
                        pad_a  <= pat_rot[PAT_WIDTH-1];
                        idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    end
                    default: pad_a <= 1'b0;
                endcase
            end
        end
    end
endmodule

module tt_heartbeat_multi #(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 16,
    parameter int PAT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_wr,
    input  logic [3:0]           cfg_ch,
    input  logic [1:0]           cfg_mode,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [PAT_WIDTH-1:0] cfg_data,
    output logic [NUM_CH-1:0]    pad_a,
    output logic [NUM_CH-1:0]    pad_oe,
    output logic                 sync_pulse
);
    logic [NUM_CH-1:0] period_end;

    // Indices >= NUM_CH match no instance, so such writes fall on the floor.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tt_heartbeat_ch #(
            .DIV_WIDTH (DIV_WIDTH),
            .PAT_WIDTH (PAT_WIDTH),
            .SYNC_EN   (i == 0)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .wr         (cfg_wr && (cfg_ch == 4'(i))),
            .cfg_mode   (cfg_mode),
            .cfg_div    (cfg_div),
            .cfg_data   (cfg_data),
            .pad_a      (pad_a[i]),
            .pad_oe     (pad_oe[i]),
            .period_end (period_end[i])
        );
    end

    // Only channel 0 can raise period_end; the OR keeps every bit in use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_pulse <= 1'b0;
        else        sync_pulse <= |period_end;
    end
endmodule

// File: tb/tb_tt_heartbeat_multi.sv
// Directed bench for tt_heartbeat_multi: reset, toggle/PWM/pattern modes, enable freeze,
// write/tick collision, out-of-range channel and asynchronous reset.

module tb_tt_heartbeat_multi;
    localparam int NUM_CH    = 4;
    localparam int DIV_WIDTH = 16;
    localparam int PAT_WIDTH = 8;
    localparam logic [1:0] M_OFF = 2'd0, M_TOG = 2'd1, M_PWM = 2'd2, M_PAT = 2'd3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic                 cfg_wr = 1'b0;
    logic [3:0]           cfg_ch = '0;
    logic [1:0]           cfg_mode = '0;
    logic [DIV_WIDTH-1:0] cfg_div = '0;
    logic [PAT_WIDTH-1:0] cfg_data = '0;
    logic [NUM_CH-1:0]    pad_a;
    logic [NUM_CH-1:0]    pad_oe;
    logic                 sync_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tt_heartbeat_multi #(
        .NUM_CH    (NUM_CH),
        .DIV_WIDTH (DIV_WIDTH),
        .PAT_WIDTH (PAT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_div    (cfg_div),
        .cfg_data   (cfg_data),
        .pad_a      (pad_a),
        .pad_oe     (pad_oe),
        .sync_pulse (sync_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] ch, input logic [1:0] mode,
                         input logic [DIV_WIDTH-1:0] div, input logic [PAT_WIDTH-1:0] data);
        cfg_ch   = ch;
        cfg_mode = mode;
        cfg_div  = div;
        cfg_data = data;
        cfg_wr   = 1'b1;
        cyc(1);
        cfg_wr   = 1'b0;
    endtask

    initial begin
        bit tbl [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int hi, lo, sy, n;

        // Reset and idle
        cyc(3);
        chk("rst_pad_a", pad_a, 4'h0);
        chk("rst_pad_oe", pad_oe, 4'h0);
        chk("rst_sync", sync_pulse, 1'b0);
        rst_n = 1'b1;
        cyc(20);
        chk("idle_pad_a", pad_a, 4'h0);
        chk("idle_pad_oe", pad_oe, 4'h0);
        chk("idle_sync", sync_pulse, 1'b0);
        en = 1'b1;

        // ch0 TOGGLE div=3: rises 4 cycles after write, period 8, sync with each fall
        write(4'd0, M_TOG, 16'd3, 8'h00);
        chk("tog_oe", pad_oe, 4'b0001);
        chk("tog_a0", pad_a, 4'h0);
        for (int k = 1; k <= 31; k++) begin
            cyc(1);
            chk("tog_pad", pad_a[0], ((k / 4) % 2));
            chk("tog_sync", sync_pulse, (k % 8 == 0) ? 1 : 0);
        end

        // Write lands on the tick that would fall and pulse: new config wins
        write(4'd0, M_PAT, 16'd2, 8'h80);
        chk("coll_pad", pad_a[0], 1'b1);
        chk("coll_sync", sync_pulse, 1'b0);
        chk("coll_oe", pad_oe[0], 1'b1);
        for (int j = 1; j <= 24; j++) begin
            cyc(1);
            chk("coll_pat", pad_a[0], (j < 3 || j == 24) ? 1 : 0);
            chk("coll_pat_sync", sync_pulse, (j == 24) ? 1 : 0);
        end
        write(4'd0, M_OFF, 16'd0, 8'h00);
        chk("off_oe", pad_oe, 4'h0);
        chk("off_a", pad_a, 4'h0);
        chk("off_sync", sync_pulse, 1'b0);

        // Out-of-range channel is ignored
        write(4'd9, M_PAT, 16'd0, 8'hFF);
        chk("bad_ch_oe", pad_oe, 4'h0);
        chk("bad_ch_a", pad_a, 4'h0);
        cyc(3);
        chk("bad_ch_oe2", pad_oe, 4'h0);
        chk("bad_ch_a2", pad_a, 4'h0);

        // ch1 PWM div=0 duty=64: high 64 of 256 cycles
        write(4'd1, M_PWM, 16'd0, 8'd64);
        chk("pwm64_init", pad_a[1], 1'b1);
        hi = 0; sy = 0;
        for (int k = 1; k <= 256; k++) begin
            cyc(1);
            hi += int'(pad_a[1]);
            sy += int'(sync_pulse);
            if (k == 63)  chk("pwm64_ph63", pad_a[1], 1'b1);
            if (k == 64)  chk("pwm64_ph64", pad_a[1], 1'b0);
            if (k == 256) chk("pwm64_ph0", pad_a[1], 1'b1);
        end
        chk("pwm64_high", hi, 64);
        chk("pwm64_nosync", sy, 0);

        // Duty 0: never high
        write(4'd1, M_PWM, 16'd0, 8'd0);
        chk("pwm0_init", pad_a[1], 1'b0);
        chk("pwm0_oe", pad_oe[1], 1'b1);
        hi = 0;
        for (int k = 1; k <= 256; k++) begin
            cyc(1);
            hi += int'(pad_a[1]);
        end
        chk("pwm0_high", hi, 0);

        // Duty 255: low exactly once per 256
        write(4'd1, M_PWM, 16'd0, 8'd255);
        chk("pwm255_init", pad_a[1], 1'b1);
        lo = 0;
        for (int k = 1; k <= 256; k++) begin
            cyc(1);
            lo += int'(!pad_a[1]);
            if (k == 255) chk("pwm255_ph255", pad_a[1], 1'b0);
        end
        chk("pwm255_low", lo, 1);

        // ch2 PATTERN 1011_0001 div=1
        write(4'd2, M_PAT, 16'd1, 8'hB1);
        chk("pat_init", pad_a[2], 1'b1);
        for (int j = 1; j <= 32; j++) begin
            cyc(1);
            n = j / 2;
            chk("pat_seq", pad_a[2], (n == 0) ? 1 : int'(tbl[(n - 1) % 8]));
        end

        // Freeze mid-PWM on ch1 (duty=3): phase 1 held, then 2 (high), 3 (low)
        write(4'd1, M_PWM, 16'd0, 8'd3);
        cyc(1);
        chk("frz_ph1", pad_a[1], 1'b1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) write(4'd3, M_TOG, 16'd5, 8'h00);
            else        cyc(1);
            chk("frz_hold", pad_a[1], 1'b1);
        end
        chk("frz_wr_oe", pad_oe, 4'b1110);
        chk("frz_wr_a3", pad_a[3], 1'b0);
        en = 1'b1;
        cyc(1);
        chk("resume_ph2", pad_a[1], 1'b1);
        cyc(1);
        chk("resume_ph3", pad_a[1], 1'b0);
        cyc(3);
        chk("ch3_pre_tick", pad_a[3], 1'b0);
        cyc(1);
        chk("ch3_tick", pad_a[3], 1'b1);

        // Asynchronous reset mid-run clears outputs before the next edge
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_pad_a", pad_a, 4'h0);
        chk("arst_pad_oe", pad_oe, 4'h0);
        chk("arst_sync", sync_pulse, 1'b0);
        #1;
        rst_n = 1'b1;
        cyc(10);
        chk("post_rst_oe", pad_oe, 4'h0);
        chk("post_rst_a", pad_a, 4'h0);
        chk("post_rst_sync", sync_pulse, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tt_heartbeat_multi.md
Name: tt_heartbeat_multi

Overview:
- Multi-channel, runtime-configurable heartbeat generator; parametrised successor of the single fixed-rate heartbeat inside tile cell macros.
- Each channel drives one pad output with its own prescaler and one of four modes: off, toggle, PWM or rotating pattern.
- Channel 0 also provides a frame-sync pulse for scope triggering.
- Sits between the cell macro's pad wrapper (pad A/OE pins) and a simple register-write port.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- DIV_WIDTH, 16, prescaler divisor width.
- PAT_WIDTH, 8, PWM phase and pattern register width (≥2).

Ports:
- clk  input  1  core clock, taken from the clock pad Y.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global run enable; low freezes all prescalers and channel state.
- cfg_wr  input  1  single-cycle configuration write strobe.
- cfg_ch  input  4  target channel index for cfg_wr.
- cfg_mode  input  2  00 OFF, 01 TOGGLE, 10 PWM, 11 PATTERN.
- cfg_div  input  DIV_WIDTH  prescaler divisor D; tick period is D+1 cycles.
- cfg_data  input  PAT_WIDTH  PWM duty, or pattern bits.
- pad_a  output  NUM_CH  per-channel pad data, registered.
- pad_oe  output  NUM_CH  per-channel pad output enable, registered.
- sync_pulse  output  1  one-cycle channel-0 period marker, registered.

Behaviour:
- Reset (async, rst_n=0): every channel mode=OFF, div=0, data=0, prescaler=0, phase=0; pad_a=0, pad_oe=0, sync_pulse=0. Reset mid-operation clears everything immediately; no write survives.
- Prescaler: counts 0..div.
  - tick = en && prescaler==div; prescaler then returns to 0.
  - div=0 gives a tick every enabled cycle.
  - en=0 holds prescaler and all state.
- Config write (cfg_wr=1, cfg_ch<NUM_CH), effective at that clock edge regardless of en:
  - mode/div/data are loaded; prescaler=0; phase=0; pattern index=0.
  - pad_oe[ch] = (cfg_mode!=OFF).
  - pad_a[ch] initial value: OFF 0; TOGGLE 0; PWM (cfg_data!=0); PATTERN cfg_data[MSB].
  - cfg_ch≥NUM_CH: write ignored, no state change.
- Simultaneous write and tick on the same channel: the write wins; the tick is discarded. Other channels are unaffected.
- Per-tick update, applied at the tick edge (pad_a changes on that edge):
  - OFF: pad_a stays 0.
  - TOGGLE: pad_a inverts. Period = 2(D+1) cycles.
  - PWM:
    - phase=phase+1, wrapping at 2^PAT_WIDTH; pad_a=(new phase < duty).
    - duty=0 gives constant low; duty=2^PAT_WIDTH−1 gives high for all but one phase; constant high is not reachable.
  - PATTERN:
    - pattern register rotates left by 1; pad_a = new MSB.
    - pattern index increments and wraps at PAT_WIDTH.
- After a write, the first tick occurs D+1 enabled cycles after the write edge.
- sync_pulse: high for exactly the one cycle after a channel-0 tick that completes a period:
  - TOGGLE: the 1→0 transition;
  - PWM: phase wraps to 0;
  - PATTERN: index wraps to 0;
  - OFF: never.
  - A write to channel 0 never generates a pulse.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle 20 cycles → pad_a=0, pad_oe=0, sync_pulse=0. Assert rst_n=0 asynchronously mid-run → all outputs 0 before the next edge.
- Write ch0 TOGGLE, div=3, en=1 → pad_oe[0]=1 at the write edge; pad_a[0] rises 4 cycles later and has period 8. sync_pulse is high one cycle after each falling edge of pad_a[0].
- Write ch1 PWM, div=0, duty=64 (PAT_WIDTH=8) → over 256 cycles pad_a[1] is high exactly 64 cycles (phases 1..63 plus phase 0 on wrap). Duty=0 → never high. Duty=255 → low exactly 1 of 256 cycles.
- Write ch2 PATTERN, data=0b1011_0001, div=1 → pad_a[2] starts 1, then on every 2nd cycle shows 0,1,1,0,0,0,1,1 and repeats with period 16.
- Drop en for 10 cycles mid-PWM on ch1 → pad_a and phase are frozen; on resume, the sequence continues without skipping a phase. A write to ch3 while en=0 still takes effect (pad_oe[3]=1).
- Issue cfg_wr to ch0 on the same cycle as its tick → the new config is loaded, no toggle occurs and no sync_pulse fires. cfg_ch=9 (NUM_CH=4) → no channel changes.
